// File: rtl/a2bus_trace_fifo.sv
// Apple II bus trace buffer: window-filtered, delta-timestamped capture of sampled
// bus cycles into a first-word-fall-through FIFO, gated by an arm/trigger machine.
module a2bus_trace_fifo #(
    parameter int          DEPTH         = 16,
    parameter logic [15:0] ADDR_LO       = 16'hC000,
    parameter logic [15:0] ADDR_HI       = 16'hC0FF,
    parameter logic [15:0] TRIG_ADDR     = 16'hC030,
    parameter bit          CAPTURE_READS = 1'b1
) (
    input  logic                       clk_logic,
    input  logic                       device_reset_n,
    input  logic [15:0]                addr_i,
    input  logic [7:0]                 data_i,
    input  logic                       rw_n_i,
    input  logic                       data_in_strobe_i,
    input  logic                       arm_i,
    input  logic                       disarm_i,
    input  logic                       clear_i,
    output logic [32:0]                rec_o,
    output logic                       rec_valid_o,
    input  logic                       rec_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic [7:0]                 drop_count_o,
    output logic [1:0]                 state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        DISARMED  = 2'd0,
        ARMED     = 2'd1,
        CAPTURING = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    delta, delta_next;
    logic [7:0]    drop_count;
    logic          overflow;
    logic          hit, trig, capture, pop, push_req, push, drop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        hit      = data_in_strobe_i && (addr_i >= ADDR_LO) && (addr_i <= ADDR_HI)
                   && (!rw_n_i || CAPTURE_READS);
        trig     = (state == ARMED) && data_in_strobe_i && (addr_i == TRIG_ADDR);
        capture  = !disarm_i && ((state == CAPTURING) || trig);
        pop      = (count != '0) && rec_ready_i && !clear_i;
        push_req = capture && hit && !clear_i;
        // A full FIFO still takes the push when the head leaves in the same clock.
        push     = push_req && ((count != FULL_LEVEL) || pop);
        drop     = push_req && !push;
    end

    always_comb begin
        state_next = state;
        if (disarm_i) begin
            state_next = DISARMED;
        end else begin
            case (state)
                DISARMED: if (arm_i) state_next = ARMED;
                ARMED:    if (trig)  state_next = CAPTURING;
                default:  state_next = state;
            endcase
        end
    end

    // The trigger cycle starts from zero; dropped records count as idle strobes.
    always_comb begin
        delta_next = delta;
        if (clear_i || disarm_i || state != CAPTURING) begin
            delta_next = 8'd0;
        end else if (data_in_strobe_i) begin
            delta_next = push ? 8'd0 : sat_inc8(delta);
        end
    end

    always_ff @(posedge clk_logic or negedge device_reset_n) begin
        if (!device_reset_n) begin
            state      <= DISARMED;
            delta      <= 8'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            state <= state_next;
            delta <= delta_next;
            if (clear_i) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                overflow   <= 1'b0;
                drop_count <= 8'd0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop)      count <= count + (AW+1)'(1);
                else if (pop && !push) count <= count - (AW+1)'(1);
                if (drop) begin
                    overflow   <= 1'b1;
                    drop_count <= sat_inc8(drop_count);
                end
            end
        end
    end

    always_ff @(posedge clk_logic) begin
        if (push) mem[wr_ptr] <= {delta, rw_n_i, addr_i, data_i};
    end

    assign rec_o        = mem[rd_ptr];
    assign rec_valid_o  = (count != '0);
    assign level_o      = count;
    assign overflow_o   = overflow;
    assign drop_count_o = drop_count;
    assign state_o      = state;

endmodule

// File: tb/tb_a2bus_trace_fifo.sv
// Randomised bench for a2bus_trace_fifo: two instances (reads captured / writes only)
// checked every cycle against a queue-based model, plus directed literal checks.
module tb_a2bus_trace_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  data = '0;
    logic        rw_n = 1'b1;
    logic        strobe = 1'b0;
    logic        arm = 1'b0;
    logic        disarm = 1'b0;
    logic        clear = 1'b0;
    logic        ready = 1'b0;

    logic [32:0] rec   [2];
    logic        valid [2];
    logic [4:0]  level [2];
    logic        ovf   [2];
    logic [7:0]  drops [2];
    logic [1:0]  st    [2];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    a2bus_trace_fifo #(.DEPTH(DEPTH), .CAPTURE_READS(1'b1)) dut_rw (
        .clk_logic(clk), .device_reset_n(rst_n), .addr_i(addr), .data_i(data),
        .rw_n_i(rw_n), .data_in_strobe_i(strobe), .arm_i(arm), .disarm_i(disarm),
        .clear_i(clear), .rec_o(rec[0]), .rec_valid_o(valid[0]), .rec_ready_i(ready),
        .level_o(level[0]), .overflow_o(ovf[0]), .drop_count_o(drops[0]), .state_o(st[0]));

    a2bus_trace_fifo #(.DEPTH(DEPTH), .CAPTURE_READS(1'b0)) dut_wo (
        .clk_logic(clk), .device_reset_n(rst_n), .addr_i(addr), .data_i(data),
        .rw_n_i(rw_n), .data_in_strobe_i(strobe), .arm_i(arm), .disarm_i(disarm),
        .clear_i(clear), .rec_o(rec[1]), .rec_valid_o(valid[1]), .rec_ready_i(ready),
        .level_o(level[1]), .overflow_o(ovf[1]), .drop_count_o(drops[1]), .state_o(st[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: state 0/1/2, delta, overflow, drop count, queue of records.
    int          ms  [2] = '{0, 0};
    int          md  [2] = '{0, 0};
    bit          mo  [2] = '{0, 0};
    int          mdc [2] = '{0, 0};
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [32:0] qhead(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic model_step(input int k);
        bit hit, trig, cap, pop, pushed;
        logic [32:0] r;
        hit  = strobe && addr >= 16'hC000 && addr <= 16'hC0FF && (!rw_n || k == 0);
        trig = (ms[k] == 1) && strobe && addr == 16'hC030;
        cap  = !disarm && (ms[k] == 2 || trig);
        r    = {(trig ? 8'd0 : 8'(md[k])), rw_n, addr, data};
        pop  = qsize(k) > 0 && ready && !clear;
        pushed = 0;
        if (clear) begin
            if (k == 0) q0.delete(); else q1.delete();
            mo[k] = 0;
            mdc[k] = 0;
        end else begin
            if (pop) begin
                if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (cap && hit) begin
                if (qsize(k) < DEPTH) begin
                    if (k == 0) q0.push_back(r); else q1.push_back(r);
                    pushed = 1;
                end else begin
                    mo[k] = 1;
                    if (mdc[k] < 255) mdc[k]++;
                end
            end
        end
        if (clear || disarm || trig || ms[k] != 2) md[k] = 0;
        else if (strobe) md[k] = pushed ? 0 : (md[k] < 255 ? md[k] + 1 : 255);
        if (disarm) ms[k] = 0;
        else if (ms[k] == 0 && arm) ms[k] = 1;
        else if (trig) ms[k] = 2;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                ms[k] = 0; md[k] = 0; mo[k] = 0; mdc[k] = 0;
            end
            q0.delete();
            q1.delete();
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("state[%0d]", k), 64'(st[k]), 64'(ms[k]));
            chk($sformatf("level[%0d]", k), 64'(level[k]), 64'(qsize(k)));
            chk($sformatf("valid[%0d]", k), 64'(valid[k]), 64'(qsize(k) > 0));
            chk($sformatf("overflow[%0d]", k), 64'(ovf[k]), 64'(mo[k]));
            chk($sformatf("drops[%0d]", k), 64'(drops[k]), 64'(mdc[k]));
            if (valid[k] && qsize(k) > 0)
                chk($sformatf("rec[%0d]", k), 64'(rec[k]), 64'(qhead(k)));
        end
    end

    task automatic cyc(input bit s, input logic [15:0] a, input logic [7:0] d, input bit rw,
                       input bit ar, input bit da, input bit cl, input bit rd);
        strobe = s; addr = a; data = d; rw_n = rw;
        arm = ar; disarm = da; clear = cl; ready = rd;
        @(posedge clk);
        #2;
        strobe = 0; arm = 0; disarm = 0; clear = 0;
    endtask

    task automatic hit_w(input logic [15:0] a, input bit rd);
        cyc(1, a, 8'($urandom), 0, 0, 0, 0, rd);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_state", 64'(st[0]), 64'd0);
        chk("reset_valid", 64'(valid[0]), 64'd0);
        chk("reset_level", 64'(level[0]), 64'd0);
        rst_n = 1'b1;

        // Arm and trigger on a write to the trigger address.
        cyc(0, 16'h0000, 8'h00, 1, 1, 0, 0, 0);
        cyc(1, 16'hC030, 8'h5A, 0, 0, 0, 0, 0);
        chk("trig_state", 64'(st[0]), 64'd2);
        chk("trig_valid", 64'(valid[0]), 64'd1);
        chk("trig_rec", 64'(rec[0]), 64'({8'h00, 1'b0, 16'hC030, 8'h5A}));
        chk("trig_level", 64'(level[0]), 64'd1);

        // Three out-of-window strobes, then an in-window read.
        cyc(1, 16'h0400, 8'h01, 1, 0, 0, 0, 0);
        cyc(1, 16'h0401, 8'h02, 1, 0, 0, 0, 0);
        cyc(1, 16'h0402, 8'h03, 1, 0, 0, 0, 0);
        cyc(1, 16'hC054, 8'h00, 1, 0, 0, 0, 0);
        chk("delta_model", 64'(q0[$]), 64'({8'h03, 1'b1, 16'hC054, 8'h00}));
        chk("delta_level_rw", 64'(level[0]), 64'd2);
        chk("delta_level_wo", 64'(level[1]), 64'd1);

        for (int i = 0; i < 64 && (level[0] != 0 || level[1] != 0); i++)
            cyc(0, 16'h0000, 8'h00, 1, 0, 0, 0, 1);
        chk("drain_done", 64'(level[0] | level[1]), 64'd0);

        // Overflow: 17 hits with the consumer stalled.
        for (int i = 0; i < 17; i++) hit_w(16'hC010, 0);
        chk("ovf_level", 64'(level[0]), 64'd16);
        chk("ovf_flag", 64'(ovf[0]), 64'd1);
        chk("ovf_drops", 64'(drops[0]), 64'd1);
        cyc(0, 16'h0000, 8'h00, 1, 0, 0, 0, 1);
        hit_w(16'hC011, 0);
        chk("drop_delta", 64'(q0[$][32:25]), 64'd1);
        for (int i = 0; i < 300; i++) hit_w(16'hC012, 0);
        chk("drop_sat", 64'(drops[0]), 64'd255);

        // Full FIFO: push with pop in the same clock.
        cyc(0, 16'h0000, 8'h00, 1, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) hit_w(16'hC020, 0);
        hit_w(16'hC021, 1);
        chk("fullpp_level", 64'(level[0]), 64'd16);
        chk("fullpp_ovf", 64'(ovf[0]), 64'd0);

        // Clear together with a hit.
        cyc(0, 16'h0000, 8'h00, 1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) hit_w(16'hC022, 0);
        chk("pre_clear_level", 64'(level[0]), 64'd5);
        cyc(1, 16'hC023, 8'h77, 0, 0, 0, 1, 0);
        chk("clear_level", 64'(level[0]), 64'd0);
        chk("clear_valid", 64'(valid[0]), 64'd0);
        chk("clear_state", 64'(st[0]), 64'd2);

        // Disarmed: window hits ignored; disarm beats arm.
        cyc(0, 16'h0000, 8'h00, 1, 0, 1, 0, 0);
        for (int i = 0; i < 256; i += 17) hit_w(16'hC000 + 16'(i), 0);
        hit_w(16'hC0FF, 0);
        chk("disarmed_level", 64'(level[0]), 64'd0);
        cyc(0, 16'h0000, 8'h00, 1, 1, 1, 0, 0);
        chk("arm_disarm", 64'(st[0]), 64'd0);
        cyc(0, 16'h0000, 8'h00, 1, 1, 0, 0, 0);
        chk("armed", 64'(st[0]), 64'd1);
        // A read trigger is not a hit for the writes-only instance.
        cyc(1, 16'hC030, 8'h11, 1, 0, 0, 0, 0);
        chk("rtrig_state_wo", 64'(st[1]), 64'd2);
        chk("rtrig_level_wo", 64'(level[1]), 64'd0);
        chk("rtrig_level_rw", 64'(level[0]), 64'd1);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            int sel;
            logic [15:0] a;
            sel = $urandom_range(0, 99);
            if (sel < 25) a = 16'hC030;
            else if (sel < 65) a = 16'hC000 | 16'($urandom_range(0, 255));
            else a = 16'($urandom);
            cyc($urandom_range(0, 99) < 60, a, 8'($urandom), 1'($urandom),
                $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2,
                $urandom_range(0, 199) < 2,
                ((i / 200) % 2 == 0) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 20));
        end

        // Reset in the middle of a drain.
        cyc(0, 16'h0000, 8'h00, 1, 0, 1, 0, 0);
        cyc(0, 16'h0000, 8'h00, 1, 1, 0, 1, 0);
        cyc(1, 16'hC030, 8'h42, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) hit_w(16'hC040, 0);
        cyc(0, 16'h0000, 8'h00, 1, 0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(valid[0]), 64'd0);
        chk("rst_level", 64'(level[0]), 64'd0);
        chk("rst_state", 64'(st[0]), 64'd0);
        chk("rst_ovf", 64'(ovf[0]), 64'd0);
        chk("rst_drops", 64'(drops[0]), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
